io_char_responder: RTL and testbench

- I/O-side responder on the MERA-400 system bus. It answers CPU IN/OU cycles (in_ asserted together with w_ or r_) addressed to one character device.
- Holds a one-byte TX holding register feeding an external serializer, and an RX FIFO filled by an external deserializer.
- Replies with exactly one of ok_ / en_ / pe_. This is the I/O counterpart of the memory responder; it never answers memory cycles (in_ inactive).

---
 rtl/io_char_responder_if.sv | 23 ++
 rtl/io_char_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_io_char_responder.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_char_responder_if.sv
// MERA-400 I/O-cycle bus bundle between the CPU (master) and a
// character-device responder (slave). All signals are active-low.
interface io_char_responder_if;
    logic        w_;
    logic        r_;
    logic        in_;
    logic [0:15] ad_;
    logic [0:15] dt_in_;
    logic [0:15] dt_out_;
    logic        ok_;
    logic        en_;
    logic        pe_;

    modport master (
        output w_, r_, in_, ad_, dt_in_,
        input  dt_out_, ok_, en_, pe_
    );

    modport slave (
        input  w_, r_, in_, ad_, dt_in_,
        output dt_out_, ok_, en_, pe_
    );
endinterface

// File: rtl/io_char_responder.sv
// MERA-400 character-device I/O responder: TX holding register, RX FIFO.
// Optional IO_CHAR_IRQ_EN adds a maskable irq_ output and writable status.
module io_char_responder #(
    parameter logic [4:0] DEV_NUM  = 5'd1,
    parameter int         RX_DEPTH = 4
) (
    input  logic               clk,
    input  logic               clo_,
    io_char_responder_if.slave bus,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid
`ifdef IO_CHAR_IRQ_EN
    ,
    output logic               irq_
`endif
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_RESP,
        S_IGNORE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [0:15] w_ad;
    logic [0:15] w_din;
    logic        w_wr;
    logic        w_rd;
    logic        w_strobe;
    logic        w_sel;
    logic        w_stat;

    logic        r_ok_;
    logic        r_en_;
    logic        r_pe_;
    logic [0:15] r_dout_;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;

    logic [7:0]  r_mem [RX_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic        r_ovr;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_mask;
    logic [0:15] w_status;

    logic        w_ok;
    logic        w_en;
    logic        w_pe;
    logic [0:15] w_dout;
    logic        w_load;
    logic        w_pop;
    logic        w_ovr_clr;
`ifdef IO_CHAR_IRQ_EN
    logic        w_mask_ld;
    logic        r_mask;
    logic        r_irq_;
`endif

    assign w_ad     = ~bus.ad_;
    assign w_din    = ~bus.dt_in_;
    assign w_wr     = ~bus.w_;
    assign w_rd     = ~bus.r_;
    assign w_strobe = w_wr | w_rd;
    assign w_sel    = ~bus.in_ & w_strobe &
                      (w_ad[10:14] == DEV_NUM);
    assign w_stat   = w_ad[15];

    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == CW'(RX_DEPTH));
    // A full FIFO still accepts a byte when the head leaves this cycle
    assign w_push   = rx_valid & (~w_full | w_pop);
    assign w_status = {12'h000, w_mask, r_ovr,
                       ~r_tx_valid, ~w_empty};

    always_ff @(posedge clk or negedge clo_) begin
        if (!clo_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_strobe) begin
                    w_next = w_sel ? S_DECODE : S_IGNORE;
                end
            end
            S_DECODE: w_next = w_strobe ? S_RESP : S_IDLE;
            S_RESP:   w_next = w_strobe ? S_RESP : S_IDLE;
            S_IGNORE: w_next = w_strobe ? S_IGNORE : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ok      = 1'b0;
        w_en      = 1'b0;
        w_pe      = 1'b0;
        w_dout    = '0;
        w_load    = 1'b0;
        w_pop     = 1'b0;
        w_ovr_clr = 1'b0;
`ifdef IO_CHAR_IRQ_EN
        w_mask_ld = 1'b0;
`endif
        if (r_state == S_DECODE && w_strobe) begin
            unique case (1'b1)
                w_wr && w_rd: w_pe = 1'b1;
                w_wr && !w_rd && w_stat: begin
`ifdef IO_CHAR_IRQ_EN
                    w_ok      = 1'b1;
                    w_mask_ld = 1'b1;
`else
                    w_pe      = 1'b1;
`endif
                end
                w_wr && !w_rd && !w_stat: begin
                    if (r_tx_valid) begin
                        w_en = 1'b1;
                    end else begin
                        w_ok   = 1'b1;
                        w_load = 1'b1;
                    end
                end
                !w_wr && w_stat: begin
                    w_ok      = 1'b1;
                    w_dout    = w_status;
                    w_ovr_clr = 1'b1;
                end
                !w_wr && !w_stat: begin
                    if (w_empty) begin
                        w_en = 1'b1;
                    end else begin
                        w_ok   = 1'b1;
                        w_pop  = 1'b1;
                        w_dout = {8'h00, r_mem[r_rp]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Reply is latched in DECODE and held until both strobes rise
    always_ff @(posedge clk or negedge clo_) begin
        if (!clo_) begin
            r_ok_   <= 1'b1;
            r_en_   <= 1'b1;
            r_pe_   <= 1'b1;
            r_dout_ <= 16'hFFFF;
        end else if (r_state == S_DECODE) begin
            r_ok_   <= ~w_ok;
            r_en_   <= ~w_en;
            r_pe_   <= ~w_pe;
            r_dout_ <= ~w_dout;
        end else if (r_state != S_RESP || !w_strobe) begin
            r_ok_   <= 1'b1;
            r_en_   <= 1'b1;
            r_pe_   <= 1'b1;
            r_dout_ <= 16'hFFFF;
        end
    end

    always_ff @(posedge clk or negedge clo_) begin
        if (!clo_) begin
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else if (w_load) begin
            r_tx_data  <= w_din[8:15];
            r_tx_valid <= 1'b1;
        end else if (r_tx_valid && tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge clo_) begin
        if (!clo_) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovr <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (rx_valid && !w_push) begin
                r_ovr <= 1'b1;
            end else if (w_ovr_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

`ifdef IO_CHAR_IRQ_EN
    always_ff @(posedge clk or negedge clo_) begin
        if (!clo_) begin
            r_mask <= 1'b0;
            r_irq_ <= 1'b1;
        end else begin
            if (w_mask_ld) begin
                r_mask <= w_din[12];
            end
            r_irq_ <= ~(r_mask & (~w_empty | ~r_tx_valid));
        end
    end

    assign w_mask = r_mask;
    assign irq_   = r_irq_;
`else
    assign w_mask = 1'b0;
`endif

    assign bus.ok_     = r_ok_;
    assign bus.en_     = r_en_;
    assign bus.pe_     = r_pe_;
    assign bus.dt_out_ = r_dout_;
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;

endmodule

// File: tb/tb_io_char_responder.sv
// Scoreboard bench for io_char_responder: bus model predicts each reply
// at drive time; tasks pop and compare when the DUT answers.
module tb_io_char_responder;

    localparam logic [4:0] DEV = 5'd1;
    localparam logic [2:0] OK  = 3'b100;
    localparam logic [2:0] EN  = 3'b010;
    localparam logic [2:0] PE  = 3'b001;

    typedef struct packed {
        logic [2:0]  rep;
        logic [15:0] dout;
    } exp_t;

    logic       clk = 1'b0;
    logic       clo_;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
`ifdef IO_CHAR_IRQ_EN
    logic       irq_;
`endif

    io_char_responder_if bus ();

    io_char_responder #(
        .DEV_NUM  (DEV),
        .RX_DEPTH (4)
    ) dut (
        .clk      (clk),
        .clo_     (clo_),
        .bus      (bus),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
`ifdef IO_CHAR_IRQ_EN
        ,
        .irq_     (irq_)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t       sb[$];
    logic [7:0] m_fifo[$];
    bit         m_txfull;
    bit         m_ovr;
    bit         m_mask;

    logic [2:0]  rep;
    logic [15:0] dout;
    int          lat;
    bit          rel;
    exp_t        e;

    function automatic exp_t model_cycle(bit wr, bit rd,
                                         logic [4:0] dev, bit st,
                                         logic [15:0] wd);
        exp_t x;
        x = '0;
        if (dev != DEV) return x;
        if (wr && rd) begin
            x.rep = PE;
        end else if (wr && st) begin
`ifdef IO_CHAR_IRQ_EN
            x.rep  = OK;
            m_mask = wd[3];
`else
            x.rep = PE;
`endif
        end else if (wr) begin
            if (m_txfull) begin
                x.rep = EN;
            end else begin
                x.rep    = OK;
                m_txfull = 1'b1;
            end
        end else if (st) begin
            x.rep  = OK;
            x.dout = {12'h000, m_mask, m_ovr, !m_txfull,
                      m_fifo.size() != 0};
            m_ovr  = 1'b0;
        end else if (m_fifo.size() == 0) begin
            x.rep = EN;
        end else begin
            x.rep  = OK;
            x.dout = {8'h00, m_fifo.pop_front()};
        end
        return x;
    endfunction

    task automatic bus_idle();
        bus.w_     = 1'b1;
        bus.r_     = 1'b1;
        bus.in_    = 1'b1;
        bus.ad_    = 16'hFFFF;
        bus.dt_in_ = 16'hFFFF;
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_txfull = 1'b0;
        m_ovr    = 1'b0;
        m_mask   = 1'b0;
    endtask

    // hold < 2 strobes only long enough to be aborted in DECODE
    task automatic bus_xfer(input bit wr, input bit rd,
                            input logic [4:0] dev, input bit st,
                            input logic [15:0] wd, input int hold,
                            output logic [2:0] o_rep,
                            output logic [15:0] o_dout,
                            output int o_lat, output bit o_rel);
        logic [15:0] a;
        a = {10'h000, dev, st};
        @(negedge clk);
        if (hold < 2) sb.push_back(exp_t'(0));
        else sb.push_back(model_cycle(wr, rd, dev, st, wd));
        bus.in_    = 1'b0;
        bus.ad_    = ~a;
        bus.dt_in_ = ~wd;
        bus.w_     = ~wr;
        bus.r_     = ~rd;
        o_rep  = '0;
        o_dout = '0;
        o_lat  = -1;
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk);
            #1;
            if (o_lat < 0 &&
                {bus.ok_, bus.en_, bus.pe_} != 3'b111) begin
                o_lat  = i;
                o_rep  = ~{bus.ok_, bus.en_, bus.pe_};
                o_dout = ~bus.dt_out_;
            end
        end
        @(negedge clk);
        bus_idle();
        @(posedge clk);
        #1;
        o_rel = bus.ok_ && bus.en_ && bus.pe_ &&
                (bus.dt_out_ === 16'hFFFF);
    endtask

    task automatic push_rx(input logic [7:0] b);
        @(negedge clk);
        if (m_fifo.size() == 4) m_ovr = 1'b1;
        else m_fifo.push_back(b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        clo_ = 1'b0;
        bus_idle();
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.ok_, bus.en_, bus.pe_} !== 3'b111) begin
            errors++;
            $display("FAIL reset_reply: got %b want 111",
                     {bus.ok_, bus.en_, bus.pe_});
        end
        checks++;
        if (bus.dt_out_ !== 16'hFFFF || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: dt_out_=%h tx_valid=%b want FFFF 0",
                     bus.dt_out_, tx_valid);
        end
        @(negedge clk);
        clo_ = 1'b1;
    endtask

    task automatic test_tx();
        bus_xfer(1, 0, DEV, 0, 16'h0041, 4, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (rep !== e.rep || lat !== 2 || !rel) begin
            errors++;
            $display("FAIL tx_write1: rep=%b lat=%0d rel=%b want %b 2 1",
                     rep, lat, rel, e.rep);
        end
        checks++;
        if (tx_data !== 8'h41 || tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL tx_load: data=%h valid=%b want 41 1",
                     tx_data, tx_valid);
        end
        bus_xfer(1, 0, DEV, 0, 16'h0099, 4, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (rep !== e.rep || lat !== 2 || !rel) begin
            errors++;
            $display("FAIL tx_write_busy: rep=%b lat=%0d want %b 2",
                     rep, lat, e.rep);
        end
        checks++;
        if (tx_data !== 8'h41) begin
            errors++;
            $display("FAIL tx_hold: data=%h want 41", tx_data);
        end
        @(negedge clk);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL tx_drain: valid=%b want 0", tx_valid);
        end
        @(negedge clk);
        tx_ready = 1'b0;
        m_txfull = 1'b0;
    endtask

    task automatic test_rx_overrun();
        logic [7:0] bytes [5];
        bytes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        foreach (bytes[i]) push_rx(bytes[i]);
        bus_xfer(0, 1, DEV, 1, 16'h0, 4, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (rep !== e.rep || dout !== e.dout || dout !== 16'h0007 ||
            lat !== 2 || !rel) begin
            errors++;
            $display("FAIL rx_status_ovr: rep=%b dout=%h want %b %h",
                     rep, dout, e.rep, e.dout);
        end
        for (int i = 0; i < 5; i++) begin
            bus_xfer(0, 1, DEV, 0, 16'h0, 4, rep, dout, lat, rel);
            e = sb.pop_front();
            checks++;
            if (rep !== e.rep || dout !== e.dout ||
                lat !== 2 || !rel) begin
                errors++;
                $display("FAIL rx_read%0d: rep=%b dout=%h want %b %h",
                         i, rep, dout, e.rep, e.dout);
            end
        end
        bus_xfer(0, 1, DEV, 1, 16'h0, 4, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (rep !== e.rep || dout !== e.dout || lat !== 2) begin
            errors++;
            $display("FAIL rx_status_clr: rep=%b dout=%h want %b %h",
                     rep, dout, e.rep, e.dout);
        end
    endtask

    task automatic test_ignore();
        bus_xfer(0, 1, 5'd2, 1, 16'h0, 20, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (rep !== e.rep || lat !== -1 || !rel) begin
            errors++;
            $display("FAIL ignore_other_dev: rep=%b lat=%0d want 000 -1",
                     rep, lat);
        end
        bus_xfer(0, 1, DEV, 1, 16'h0, 4, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (rep !== e.rep || dout !== e.dout || lat !== 2) begin
            errors++;
            $display("FAIL ignore_then_valid: rep=%b dout=%h want %b %h",
                     rep, dout, e.rep, e.dout);
        end
    endtask

    task automatic test_abort();
        push_rx(8'h77);
        bus_xfer(0, 1, DEV, 0, 16'h0, 1, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (rep !== e.rep || lat !== -1 || !rel) begin
            errors++;
            $display("FAIL abort_noreply: rep=%b lat=%0d rel=%b want 000 -1 1",
                     rep, lat, rel);
        end
        bus_xfer(0, 1, DEV, 0, 16'h0, 4, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (rep !== e.rep || dout !== e.dout || dout !== 16'h0077) begin
            errors++;
            $display("FAIL abort_fifo_kept: rep=%b dout=%h want %b %h",
                     rep, dout, e.rep, e.dout);
        end
    endtask

    task automatic test_both_strobes();
        bus_xfer(1, 1, DEV, 0, 16'h0099, 4, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (rep !== e.rep || rep !== PE || lat !== 2 || !rel) begin
            errors++;
            $display("FAIL both_strobes: rep=%b lat=%0d want %b 2",
                     rep, lat, e.rep);
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_no_tx: valid=%b want 0", tx_valid);
        end
        bus_xfer(1, 0, DEV, 1, 16'h0000, 4, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (rep !== e.rep || lat !== 2) begin
            errors++;
            $display("FAIL write_status: rep=%b want %b", rep, e.rep);
        end
        bus_xfer(0, 1, DEV, 1, 16'h0, 4, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (rep !== e.rep || dout !== e.dout || dout !== 16'h0002) begin
            errors++;
            $display("FAIL both_no_side: rep=%b dout=%h want %b %h",
                     rep, dout, e.rep, e.dout);
        end
    endtask

    task automatic test_reset_mid_resp();
        int n;
        @(negedge clk);
        bus.in_    = 1'b0;
        bus.ad_    = ~{10'h000, DEV, 1'b0};
        bus.dt_in_ = ~16'h0055;
        bus.w_     = 1'b0;
        n = 0;
        while (bus.ok_ !== 1'b0 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.ok_ !== 1'b0 || n !== 2) begin
            errors++;
            $display("FAIL rst_mid_ok_seen: ok_=%b edges=%0d want 0 2",
                     bus.ok_, n);
        end
        @(negedge clk);
        clo_ = 1'b0;
        #1;
        checks++;
        if (bus.ok_ !== 1'b1 || bus.dt_out_ !== 16'hFFFF) begin
            errors++;
            $display("FAIL rst_mid_bus: ok_=%b dt_out_=%h want 1 FFFF",
                     bus.ok_, bus.dt_out_);
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_tx: valid=%b want 0", tx_valid);
        end
        bus_idle();
        model_reset();
        @(negedge clk);
        clo_ = 1'b1;
        bus_xfer(0, 1, DEV, 1, 16'h0, 4, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (rep !== e.rep || dout !== e.dout || dout !== 16'h0002) begin
            errors++;
            $display("FAIL rst_mid_status: rep=%b dout=%h want %b %h",
                     rep, dout, e.rep, e.dout);
        end
    endtask

`ifdef IO_CHAR_IRQ_EN
    task automatic test_irq();
        bus_xfer(1, 0, DEV, 0, 16'h005A, 4, rep, dout, lat, rel);
        e = sb.pop_front();
        bus_xfer(1, 0, DEV, 1, 16'h0008, 4, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (rep !== e.rep || rep !== OK || irq_ !== 1'b1) begin
            errors++;
            $display("FAIL irq_mask_wr: rep=%b irq_=%b want %b 1",
                     rep, irq_, e.rep);
        end
        push_rx(8'h33);
        checks++;
        if (irq_ !== 1'b1) begin
            errors++;
            $display("FAIL irq_latency: irq_=%b want 1", irq_);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq_ !== 1'b0) begin
            errors++;
            $display("FAIL irq_rx: irq_=%b want 0", irq_);
        end
        bus_xfer(0, 1, DEV, 0, 16'h0, 4, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (dout !== e.dout || irq_ !== 1'b1) begin
            errors++;
            $display("FAIL irq_drain: dout=%h irq_=%b want %h 1",
                     dout, irq_, e.dout);
        end
        bus_xfer(0, 1, DEV, 1, 16'h0, 4, rep, dout, lat, rel);
        e = sb.pop_front();
        checks++;
        if (dout !== e.dout || dout !== 16'h0008) begin
            errors++;
            $display("FAIL irq_status: dout=%h want %h", dout, e.dout);
        end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tx();
        test_rx_overrun();
        test_ignore();
        test_abort();
        test_both_strobes();
        test_reset_mid_resp();
`ifdef IO_CHAR_IRQ_EN
        test_irq();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d entries want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
